// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller: function codes, class decode,
// FSM encoding and default sizing.
package alu_pkg;

    localparam int WIDTH_DEFAULT   = 16;
    localparam int TIMEOUT_DEFAULT = 4;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_MUL  = 4'h2;
    localparam logic [3:0] FN_DIV  = 4'h3;
    localparam logic [3:0] FN_AND  = 4'h4;
    localparam logic [3:0] FN_OR   = 4'h5;
    localparam logic [3:0] FN_NAND = 4'h6;
    localparam logic [3:0] FN_NOR  = 4'h7;
    localparam logic [3:0] FN_NOP  = 4'h8;
    localparam logic [3:0] FN_EQ   = 4'h9;
    localparam logic [3:0] FN_GT   = 4'hA;
    localparam logic [3:0] FN_LT   = 4'hB;
    localparam logic [3:0] FN_SLL  = 4'hC;
    localparam logic [3:0] FN_SRL  = 4'hD;
    localparam logic [3:0] FN_SRA  = 4'hE;
    localparam logic [3:0] FN_ROL  = 4'hF;

    typedef enum logic [2:0] {
        CLS_ARITH,
        CLS_LOGIC,
        CLS_NOP,
        CLS_CMP,
        CLS_SHIFT
    } func_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic func_cls_e func_class(input logic [3:0] f);
        func_cls_e cls;
        case (f)
            FN_ADD, FN_SUB, FN_MUL, FN_DIV:  cls = CLS_ARITH;
            FN_AND, FN_OR, FN_NAND, FN_NOR:  cls = CLS_LOGIC;
            FN_EQ, FN_GT, FN_LT:             cls = CLS_CMP;
            FN_SLL, FN_SRL, FN_SRA, FN_ROL:  cls = CLS_SHIFT;
            default:                         cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Command/response bus plus the ALU operand and result lines of the controller.
interface alu_ctrl_if #(
    parameter int width = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3:0]           cmd_func;
    logic [width-1:0]     cmd_a;
    logic [width-1:0]     cmd_b;

    logic [width-1:0]     alu_a;
    logic [width-1:0]     alu_b;
    logic [3:0]           alu_func;

    logic [2*width-1:0]   arith_out;
    logic                 arith_flag;
    logic [width-1:0]     logic_out;
    logic                 logic_flag;
    logic [1:0]           cmp_out;
    logic                 cmp_flag;
    logic [width-1:0]     shift_out;
    logic                 shift_flag;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*width-1:0]   rsp_data;
    logic                 rsp_err;

    modport slave (
        input  cmd_valid, cmd_func, cmd_a, cmd_b,
        input  arith_out, arith_flag, logic_out, logic_flag,
        input  cmp_out, cmp_flag, shift_out, shift_flag,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_func,
        output rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output cmd_valid, cmd_func, cmd_a, cmd_b,
        output arith_out, arith_flag, logic_out, logic_flag,
        output cmp_out, cmp_flag, shift_out, shift_flag,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_func,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_rsp_sel.sv
// Picks the result/valid pair belonging to the class of the issued function and
// widens it to the response width.
module alu_rsp_sel
    import alu_pkg::*;
#(
    parameter int width = WIDTH_DEFAULT
) (
    input  logic [3:0]         func_i,
    input  logic [2*width-1:0] arith_out_i,
    input  logic               arith_flag_i,
    input  logic [width-1:0]   logic_out_i,
    input  logic               logic_flag_i,
    input  logic [1:0]         cmp_out_i,
    input  logic               cmp_flag_i,
    input  logic [width-1:0]   shift_out_i,
    input  logic               shift_flag_i,
    output logic               flag_o,
    output logic [2*width-1:0] data_o
);

    always_comb begin
        flag_o = 1'b0;
        data_o = '0;
        case (func_class(func_i))
            CLS_ARITH: begin
                flag_o = arith_flag_i;
                data_o = arith_out_i;
            end
            CLS_LOGIC: begin
                flag_o = logic_flag_i;
                data_o = {{width{1'b0}}, logic_out_i};
            end
            CLS_CMP: begin
                flag_o = cmp_flag_i;
                data_o = {{(2*width-2){1'b0}}, cmp_out_i};
            end
            CLS_SHIFT: begin
                flag_o = shift_flag_i;
                data_o = {{width{1'b0}}, shift_out_i};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Issues one command at a time to an external ALU, waits for the matching result
// (bounded by TIMEOUT) and returns it over a valid/ready response.
//
//  state   | meaning
//  IDLE    | ready for a command; NOP and divide-by-zero answered without the ALU
//  WAIT    | operands on the ALU; waiting for the class flag or timeout
//  RESP    | response held until rsp_ready
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int width   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [width-1:0]     alu_a_q, alu_a_d;
    logic [width-1:0]     alu_b_q, alu_b_d;
    logic [3:0]           alu_func_q, alu_func_d;
    logic [2*width-1:0]   rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 sel_flag;
    logic [2*width-1:0]   sel_data;

    alu_rsp_sel #(.width(width)) u_rsp_sel (
        .func_i       (alu_func_q),
        .arith_out_i  (bus.arith_out),
        .arith_flag_i (bus.arith_flag),
        .logic_out_i  (bus.logic_out),
        .logic_flag_i (bus.logic_flag),
        .cmp_out_i    (bus.cmp_out),
        .cmp_flag_i   (bus.cmp_flag),
        .shift_out_i  (bus.shift_out),
        .shift_flag_i (bus.shift_flag),
        .flag_o       (sel_flag),
        .data_o       (sel_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= FN_NOP;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_func_q <= alu_func_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_func_d = alu_func_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d = bus.cmd_a;
                    alu_b_d = bus.cmd_b;
                    if (bus.cmd_func == FN_NOP) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_RESP;
                    end else if (bus.cmd_func == FN_DIV && bus.cmd_b == '0) begin
                        // never reaches the ALU, so alu_func is left at NOP
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        alu_func_d = bus.cmd_func;
                        cnt_d      = CNT_W'(TIMEOUT - 1);
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sel_flag) begin
                    rsp_data_d = sel_data;
                    rsp_err_d  = 1'b0;
                    alu_func_d = FN_NOP;
                    cnt_d      = '0;
                    state_d    = ST_RESP;
                end else if (cnt_q == '0) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    alu_func_d = FN_NOP;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_func  = alu_func_q;

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: width, default 16, operand width; results are 2*width wide.
REQ-002 Parameter: TIMEOUT, default 4, max cycles in WAIT before error.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_func  in  4  ALU function code.
REQ-009 cmd_a, cmd_b  in  width each  operands, two's complement.
REQ-010 alu_a, alu_b  out  width each  operands driven to the ALU.
REQ-011 alu_func  out  4  function code driven to the ALU.
REQ-012 arith_out  in  2*width; arith_flag  in  1  ALU arithmetic result and valid.
REQ-013 logic_out  in  width; logic_flag  in  1  ALU logic result and valid.
REQ-014 cmp_out  in  2; cmp_flag  in  1  ALU compare result and valid.
REQ-015 shift_out  in  width; shift_flag  in  1  ALU shift result and valid.
REQ-016 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-017 rsp_data  out  2*width  selected result.
REQ-018 rsp_err  out  1  high for timeout or divide-by-zero.

Function
REQ-019 Function codes: 0-3 add/sub/mul/div; 4-7 and/or/nand/nor; 8 NOP; 9-B compare eq/gt/lt; C-F shift.
REQ-020 FSM states IDLE, WAIT, RESP; cmd_ready SHALL be high only in IDLE with rst low.
REQ-021 IDLE: on cmd_valid&&cmd_ready, register cmd_a/cmd_b into alu_a/alu_b and cmd_func into alu_func, go WAIT.
REQ-022 Exceptions in IDLE: func 8 -> rsp_data 0, rsp_err 0, go RESP directly; func 3 with cmd_b==0 -> rsp_data 0, rsp_err 1, go RESP, alu_func stays 8.
REQ-023 WAIT: expected flag selected by alu_func class (0-3 arith, 4-7 logic, 9-B cmp, C-F shift); other flags ignored.
REQ-024 WAIT: when expected flag high at a rising edge, capture result into rsp_data, rsp_err 0, go RESP.
REQ-025 Width rule: arith_out passed unchanged; logic_out, shift_out, cmp_out zero-extended to 2*width.
REQ-026 WAIT: cycle counter; if expected flag not seen within TIMEOUT edges, rsp_data 0, rsp_err 1, go RESP.
REQ-027 alu_func SHALL return to 8 (NOP) on WAIT exit; alu_a/alu_b hold last values.
REQ-028 RESP: rsp_valid high; rsp_data/rsp_err stable until rsp_ready sampled high, then IDLE.
REQ-029 Latency: with 1-cycle ALU, rsp_valid rises 2 cycles after command handshake edge; NOP/div0 1 cycle.
REQ-030 No overlap: new command accepted no earlier than cycle after response handshake.
REQ-031 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-032 While rst high: state IDLE, cmd_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, alu_a 0, alu_b 0, alu_func 8, counter 0.
REQ-033 Reset mid-WAIT or mid-RESP SHALL abandon the operation with no response.
REQ-034 cmd_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-035 Package alu_pkg SHALL hold function codes, class decode, FSM state encoding, and TIMEOUT default.
REQ-036 One sub-module alu_rsp_sel SHALL do combinational class select and zero-extension of results.

Verification
REQ-038 Add: A=5, B=10, func 0 -> rsp_data 15, rsp_err 0, rsp_valid 2 cycles after handshake.
REQ-039 Sub signed: A=5, B=10, func 1 -> rsp_data = -5 sign-extended to 32 bits (FFFFFFFB), rsp_err 0.
REQ-040 Divide by zero: A=10, B=0, func 3 -> alu_func stays 8, rsp_err 1, rsp_data 0, rsp_valid after 1 cycle.
REQ-041 Timeout: func C, shift_flag held low -> rsp_err 1 after 4 WAIT cycles; alu_func returns to 8.
REQ-042 Backpressure: A=10, B=5, func A, rsp_ready low 5 cycles -> rsp_data 2 held stable, cmd_ready low throughout.
REQ-043 Reset mid-WAIT: assert rst during WAIT -> all outputs reset, no response; next command (func 2, 5*10) -> rsp_data 50.
